aurora_rx_frame_sorter: RTL and testbench
=========================================

Name: aurora_rx_frame_sorter

Overview:
Sits directly downstream of aurora_rx_lane in the clk_rx_i domain and consumes its descrambled 64b payload, 2b header and valid strobe.
Tracks per-lane link state and sorts blocks by type:
- data blocks go to a small first-word-fall-through (FWFT) FIFO;
- user-K/register control blocks go to a one-cycle strobe port;
- idles are dropped.
Provides saturating error and drop counters used by the lane-drop recovery logic.

Parameters:
DEPTH, 16, data FIFO depth in 64b words; power of 2, minimum 4
IDLE_LOCK, 4, consecutive idle blocks required to promote SYNCING to UP
ERR_LIMIT, 8, consecutive bad headers in UP that demote to SYNCING
CNT_W, 16, width of the status counters

Ports:
clk_rx_i  in  1  single clock, the lane's rx clock
rst_n_i  in  1  asynchronous active-low reset
rx_data_i  in  64  lane payload, bits [63:56] = control block type when header=10
rx_header_i  in  2  sync header: 01 = data, 10 = control, 00/11 = invalid
rx_valid_i  in  1  block qualifier from the lane
lane_locked_i  in  1  block-sync lock from the lane
data_o  out  64  FIFO head word
data_valid_o  out  1  FIFO non-empty
data_ready_i  in  1  consumer pop; a pop occurs when data_valid_o & data_ready_i
reg_data_o  out  64  last user-K block (full 64b)
reg_valid_o  out  1  one-cycle strobe per user-K block
link_up_o  out  1  high in state UP
fifo_level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
err_cnt_o  out  CNT_W  invalid-header plus unknown-type blocks, saturating
drop_cnt_o  out  CNT_W  data words dropped on full FIFO, saturating
ovf_o  out  1  sticky; set on the first drop
cnt_clr_i  in  1  synchronous clear of err_cnt_o, drop_cnt_o and ovf_o

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM = DOWN, idle and error run counters = 0.
- Accepted block: rx_valid_i=1 in a cycle. Cycles with rx_valid_i=0 change no state and do not break any run count.
- Control types:
  - 0x78 = IDLE;
  - 0xD2 = USER_K;
  - 0x55 = NFC, ignored and not an error;
  - any other type = UNKNOWN.
- FSM:
  - DOWN: entered whenever lane_locked_i=0, from any state, with priority over all else. Flushes the FIFO (level 0 next cycle) and clears run counters. Moves to SYNCING when lane_locked_i=1.
  - SYNCING: data and USER_K blocks are discarded and not counted. Each IDLE increments the idle run; any other accepted block resets it to 0. When the run reaches IDLE_LOCK, the state becomes UP on the next cycle.
  - UP: every invalid header increments the bad-header run; any valid header resets it. When the run reaches ERR_LIMIT, the state returns to SYNCING. The FIFO is not flushed on this transition.
- Routing, in UP only:
  - DATA: pushed to the FIFO. data_valid_o rises 1 cycle after the accepted block (latency 1).
  - USER_K: reg_data_o <= rx_data_i and reg_valid_o=1 for exactly one cycle, latency 1. reg_data_o holds its value afterwards.
  - IDLE and NFC: dropped.
- Error counting, in SYNCING and UP: each invalid header or UNKNOWN type increments err_cnt_o by 1.
- Counters: all saturate at 2^CNT_W-1. cnt_clr_i wins over a same-cycle increment; the counter reads 0 next cycle.
- FIFO:
  - Full is evaluated before the same-cycle pop. A push while full is dropped: drop_cnt_o +1 and ovf_o set, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full and not empty: level unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH. The level counter is one bit wider than the pointers so full (level = DEPTH) is distinguishable.
- Reset mid-operation: asynchronously returns every register to its reset value. The FIFO contents are discarded.

Test Plan:
1. Reset, then lane_locked_i=1 and 4 IDLE blocks → link_up_o=1 exactly one cycle after the 4th IDLE; 3 IDLEs followed by one DATA block → still SYNCING, err_cnt_o=0.
2. UP, 20 DATA blocks carrying {cnt,cnt} with data_ready_i=0 → fifo_level_o=16, drop_cnt_o=4, ovf_o=1; release ready → words cnt 0..15 read out in order.
3. UP, USER_K block 0xD2AABBCCDDEEFF00 → reg_valid_o high for one cycle at N+1, reg_data_o equal to that block; FIFO unchanged.
4. UP, 8 consecutive header=00 blocks → err_cnt_o=8, link_up_o=0 after the 8th; 7 bad headers then one DATA block → stays UP.
5. FIFO holding 5 words, lane_locked_i dropped for one cycle → fifo_level_o=0, FSM DOWN then SYNCING; counters retained.
6. err_cnt_o forced to 0xFFFE, 3 UNKNOWN blocks → 0xFFFF (saturated); cnt_clr_i asserted in the same cycle as an increment → err_cnt_o=0 and ovf_o=0.

Source files
------------

// File: rtl/aurora_rx_frame_sorter.sv
// ---------------------------------------------------------------------------
// aurora_rx_frame_sorter
//
// Purpose:
//   Sits downstream of the Aurora rx lane in the lane clock domain. It tracks
//   the link state (DOWN / SYNCING / UP) and sorts the lane's descrambled
//   64b blocks by type:
//     - data blocks are pushed into a first-word-fall-through FIFO,
//     - user-K blocks are presented on a one-cycle strobe port,
//     - idles and NFC blocks are dropped.
//   Saturating error and drop counters and a sticky overflow flag feed the
//   lane-drop recovery logic.
//
// Ports:
//   clk_rx_i       lane rx clock
//   rst_n_i        asynchronous active-low reset
//   rx_data_i      64b payload; [63:56] is the block type on control blocks
//   rx_header_i    sync header: 01 data, 10 control, 00/11 invalid
//   rx_valid_i     block qualifier
//   lane_locked_i  block-sync lock from the lane
//   data_o         FIFO head word
//   data_valid_o   FIFO non-empty
//   data_ready_i   consumer pop (pop = data_valid_o & data_ready_i)
//   reg_data_o     last user-K block
//   reg_valid_o    one-cycle strobe per user-K block
//   link_up_o      high while the link is UP
//   fifo_level_o   FIFO occupancy
//   err_cnt_o      invalid-header plus unknown-type blocks, saturating
//   drop_cnt_o     data words dropped on a full FIFO, saturating
//   ovf_o          sticky, set on the first drop
//   cnt_clr_i      synchronous clear of err_cnt_o, drop_cnt_o and ovf_o
// ---------------------------------------------------------------------------
module aurora_rx_frame_sorter #(
   parameter int DEPTH     = 16,
   parameter int IDLE_LOCK = 4,
   parameter int ERR_LIMIT = 8,
   parameter int CNT_W     = 16
) (
   input  logic                     clk_rx_i,
   input  logic                     rst_n_i,
   input  logic [63:0]              rx_data_i,
   input  logic [1:0]               rx_header_i,
   input  logic                     rx_valid_i,
   input  logic                     lane_locked_i,
   output logic [63:0]              data_o,
   output logic                     data_valid_o,
   input  logic                     data_ready_i,
   output logic [63:0]              reg_data_o,
   output logic                     reg_valid_o,
   output logic                     link_up_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic [CNT_W-1:0]         err_cnt_o,
   output logic [CNT_W-1:0]         drop_cnt_o,
   output logic                     ovf_o,
   input  logic                     cnt_clr_i
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int IDLE_W = $clog2(IDLE_LOCK + 1);
   localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

   localparam logic [7:0] TYPE_IDLE   = 8'h78;
   localparam logic [7:0] TYPE_USER_K = 8'hD2;
   localparam logic [7:0] TYPE_NFC    = 8'h55;

   typedef enum logic [1:0] {
      ST_DOWN    = 2'd0,
      ST_SYNCING = 2'd1,
      ST_UP      = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDLE_W-1:0]  idle_run_q, idle_run_d;
   logic [ERR_W-1:0]   bad_run_q, bad_run_d;
   logic               link_up_q, link_up_d;
   logic [63:0]        reg_data_q, reg_data_d;
   logic               reg_valid_q, reg_valid_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [63:0]        mem_q [DEPTH];

   logic       hdr_data, hdr_ctrl, hdr_bad;
   logic [7:0] blk_type;
   logic       is_idle, is_user_k, is_nfc, is_unknown;
   logic       push_req, do_push, do_pop, drop, flush, err_inc;
   logic       fifo_full, fifo_empty;

   // Block decode
   always_comb begin
      hdr_data   = (rx_header_i == 2'b01);
      hdr_ctrl   = (rx_header_i == 2'b10);
      hdr_bad    = !(hdr_data || hdr_ctrl);
      blk_type   = rx_data_i[63:56];
      is_idle    = hdr_ctrl && (blk_type == TYPE_IDLE);
      is_user_k  = hdr_ctrl && (blk_type == TYPE_USER_K);
      is_nfc     = hdr_ctrl && (blk_type == TYPE_NFC);
      is_unknown = hdr_ctrl && !(is_idle || is_user_k || is_nfc);
   end

   // Link FSM, run counters and block routing. Loss of lane lock overrides
   // everything: the FIFO is flushed and no block is processed that cycle.
   always_comb begin
      state_d     = state_q;
      idle_run_d  = idle_run_q;
      bad_run_d   = bad_run_q;
      reg_data_d  = reg_data_q;
      reg_valid_d = 1'b0;
      push_req    = 1'b0;
      err_inc     = 1'b0;
      flush       = 1'b0;

      if (!lane_locked_i) begin
         state_d    = ST_DOWN;
         idle_run_d = '0;
         bad_run_d  = '0;
         flush      = 1'b1;
      end else begin
         case (state_q)
            ST_DOWN: begin
               state_d = ST_SYNCING;
            end
            ST_SYNCING: begin
               if (rx_valid_i) begin
                  err_inc = hdr_bad || is_unknown;
                  if (is_idle) begin
                     // The run completing on this block promotes on this edge,
                     // so link_up_o rises one cycle after the last idle.
                     if (idle_run_q == IDLE_W'(IDLE_LOCK - 1)) begin
                        state_d    = ST_UP;
                        idle_run_d = '0;
                        bad_run_d  = '0;
                     end else begin
                        idle_run_d = idle_run_q + IDLE_W'(1);
                     end
                  end else begin
                     idle_run_d = '0;
                  end
               end
            end
            ST_UP: begin
               if (rx_valid_i) begin
                  err_inc = hdr_bad || is_unknown;
                  if (hdr_bad) begin
                     // FIFO contents survive the demotion to SYNCING.
                     if (bad_run_q == ERR_W'(ERR_LIMIT - 1)) begin
                        state_d    = ST_SYNCING;
                        bad_run_d  = '0;
                        idle_run_d = '0;
                     end else begin
                        bad_run_d = bad_run_q + ERR_W'(1);
                     end
                  end else begin
                     bad_run_d = '0;
                     push_req  = hdr_data;
                     if (is_user_k) begin
                        reg_data_d  = rx_data_i;
                        reg_valid_d = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_DOWN;
            end
         endcase
      end
   end

   // FIFO control. Full is judged before any same-cycle pop, so a push into
   // a full FIFO is always dropped even when the consumer pops that cycle.
   always_comb begin
      fifo_full  = (level_q == LVL_W'(DEPTH));
      fifo_empty = (level_q == '0);
      do_push    = push_req && !fifo_full;
      drop       = push_req && fifo_full;
      do_pop     = !fifo_empty && data_ready_i && !flush;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Status counters; a clear beats a same-cycle increment.
   always_comb begin
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      if (cnt_clr_i) begin
         err_cnt_d  = '0;
         drop_cnt_d = '0;
         ovf_d      = 1'b0;
      end else begin
         if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
         if (drop) begin
            ovf_d = 1'b1;
         end
      end
      link_up_d = (state_d == ST_UP);
   end

   always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_DOWN;
         idle_run_q  <= '0;
         bad_run_q   <= '0;
         link_up_q   <= 1'b0;
         reg_data_q  <= '0;
         reg_valid_q <= 1'b0;
         err_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idle_run_q  <= idle_run_d;
         bad_run_q   <= bad_run_d;
         link_up_q   <= link_up_d;
         reg_data_q  <= reg_data_d;
         reg_valid_q <= reg_valid_d;
         err_cnt_q   <= err_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         ovf_q       <= ovf_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= rx_data_i;
         end
      end
   end

   assign data_o       = mem_q[rd_ptr_q];
   assign data_valid_o = (level_q != '0);
   assign fifo_level_o = level_q;
   assign reg_data_o   = reg_data_q;
   assign reg_valid_o  = reg_valid_q;
   assign link_up_o    = link_up_q;
   assign err_cnt_o    = err_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_aurora_rx_frame_sorter.sv
// ---------------------------------------------------------------------------
// tb_aurora_rx_frame_sorter
//
// Directed self-checking bench for aurora_rx_frame_sorter with the default
// parameters (DEPTH 16, IDLE_LOCK 4, ERR_LIMIT 8, CNT_W 16). Inputs change on
// the falling clock edge; outputs are sampled on the falling edge following
// the rising edge that consumed a block.
// ---------------------------------------------------------------------------
module tb_aurora_rx_frame_sorter;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;
   localparam logic [1:0] HDR_BAD  = 2'b00;

   localparam logic [63:0] BLK_IDLE    = 64'h7800_0000_0000_0000;
   localparam logic [63:0] BLK_NFC     = 64'h5500_0000_0000_0000;
   localparam logic [63:0] BLK_UNKNOWN = 64'h1100_0000_0000_0000;
   localparam logic [63:0] BLK_USER_K  = 64'hD2AA_BBCC_DDEE_FF00;

   logic        clk_rx_i = 1'b0;
   logic        rst_n_i;
   logic [63:0] rx_data_i;
   logic [1:0]  rx_header_i;
   logic        rx_valid_i;
   logic        lane_locked_i;
   logic [63:0] data_o;
   logic        data_valid_o;
   logic        data_ready_i;
   logic [63:0] reg_data_o;
   logic        reg_valid_o;
   logic        link_up_o;
   logic [4:0]  fifo_level_o;
   logic [15:0] err_cnt_o;
   logic [15:0] drop_cnt_o;
   logic        ovf_o;
   logic        cnt_clr_i;

   int errCount   = 0;
   int checkCount = 0;

   aurora_rx_frame_sorter dut (
      .clk_rx_i      (clk_rx_i),
      .rst_n_i       (rst_n_i),
      .rx_data_i     (rx_data_i),
      .rx_header_i   (rx_header_i),
      .rx_valid_i    (rx_valid_i),
      .lane_locked_i (lane_locked_i),
      .data_o        (data_o),
      .data_valid_o  (data_valid_o),
      .data_ready_i  (data_ready_i),
      .reg_data_o    (reg_data_o),
      .reg_valid_o   (reg_valid_o),
      .link_up_o     (link_up_o),
      .fifo_level_o  (fifo_level_o),
      .err_cnt_o     (err_cnt_o),
      .drop_cnt_o    (drop_cnt_o),
      .ovf_o         (ovf_o),
      .cnt_clr_i     (cnt_clr_i)
   );

   always #5 clk_rx_i = ~clk_rx_i;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one accepted block for a single clock and returns on the next
   // falling edge with rx_valid_i deasserted.
   task automatic applyStimulus(input logic [1:0] hdr, input logic [63:0] data);
      rx_header_i = hdr;
      rx_data_i   = data;
      rx_valid_i  = 1'b1;
      @(negedge clk_rx_i);
      rx_valid_i  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_rx_i);
      end
   endtask

   initial begin
      rst_n_i       = 1'b0;
      rx_data_i     = '0;
      rx_header_i   = '0;
      rx_valid_i    = 1'b0;
      lane_locked_i = 1'b0;
      data_ready_i  = 1'b0;
      cnt_clr_i     = 1'b0;
      idleCycles(3);
      rst_n_i = 1'b1;
      idleCycles(1);

      // Reset state
      checkOutput("rst_link_up", 64'(link_up_o), 64'd0);
      checkOutput("rst_data_valid", 64'(data_valid_o), 64'd0);
      checkOutput("rst_level", 64'(fifo_level_o), 64'd0);
      checkOutput("rst_reg_valid", 64'(reg_valid_o), 64'd0);
      checkOutput("rst_err_cnt", 64'(err_cnt_o), 64'd0);
      checkOutput("rst_ovf", 64'(ovf_o), 64'd0);
      checkOutput("rst_data", data_o, 64'd0);

      // Link bring-up: DOWN -> SYNCING needs one locked cycle
      lane_locked_i = 1'b1;
      idleCycles(1);
      for (int i = 0; i < 3; i++) applyStimulus(HDR_CTRL, BLK_IDLE);
      applyStimulus(HDR_DATA, 64'h1234);
      checkOutput("sync_data_breaks_run", 64'(link_up_o), 64'd0);
      checkOutput("sync_data_no_err", 64'(err_cnt_o), 64'd0);
      checkOutput("sync_data_not_pushed", 64'(fifo_level_o), 64'd0);
      for (int i = 0; i < 3; i++) applyStimulus(HDR_CTRL, BLK_IDLE);
      checkOutput("sync_3_idles", 64'(link_up_o), 64'd0);
      applyStimulus(HDR_CTRL, BLK_IDLE);
      checkOutput("sync_4th_idle_up", 64'(link_up_o), 64'd1);

      // Overfill: 20 data words into a 16-deep FIFO
      for (int i = 0; i < 20; i++) begin
         applyStimulus(HDR_DATA, {32'(i), 32'(i)});
      end
      checkOutput("fill_level", 64'(fifo_level_o), 64'd16);
      checkOutput("fill_drop_cnt", 64'(drop_cnt_o), 64'd4);
      checkOutput("fill_ovf", 64'(ovf_o), 64'd1);
      checkOutput("fill_valid", 64'(data_valid_o), 64'd1);
      checkOutput("fill_err_cnt", 64'(err_cnt_o), 64'd0);
      data_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("drain_word%0d", i), data_o, {32'(i), 32'(i)});
         @(negedge clk_rx_i);
      end
      data_ready_i = 1'b0;
      checkOutput("drain_empty", 64'(data_valid_o), 64'd0);
      checkOutput("drain_level", 64'(fifo_level_o), 64'd0);

      // User-K strobe with two words sitting in the FIFO
      applyStimulus(HDR_DATA, 64'hA1);
      applyStimulus(HDR_DATA, 64'hA2);
      checkOutput("userk_pre_strobe", 64'(reg_valid_o), 64'd0);
      applyStimulus(HDR_CTRL, BLK_USER_K);
      checkOutput("userk_strobe", 64'(reg_valid_o), 64'd1);
      checkOutput("userk_data", reg_data_o, BLK_USER_K);
      checkOutput("userk_fifo_level", 64'(fifo_level_o), 64'd2);
      checkOutput("userk_fifo_head", data_o, 64'hA1);
      idleCycles(1);
      checkOutput("userk_strobe_one_cycle", 64'(reg_valid_o), 64'd0);
      checkOutput("userk_data_held", reg_data_o, BLK_USER_K);

      // Bad-header run: 8 in a row demote to SYNCING without a flush
      for (int i = 0; i < 7; i++) applyStimulus(HDR_BAD, 64'h0);
      checkOutput("bad7_still_up", 64'(link_up_o), 64'd1);
      applyStimulus(HDR_BAD, 64'h0);
      checkOutput("bad8_down", 64'(link_up_o), 64'd0);
      checkOutput("bad8_err_cnt", 64'(err_cnt_o), 64'd8);
      checkOutput("bad8_level_kept", 64'(fifo_level_o), 64'd2);
      for (int i = 0; i < 4; i++) applyStimulus(HDR_CTRL, BLK_IDLE);
      checkOutput("resync_up", 64'(link_up_o), 64'd1);
      for (int i = 0; i < 7; i++) applyStimulus(HDR_BAD, 64'h0);
      applyStimulus(HDR_DATA, 64'hA3);
      checkOutput("bad7_data_up", 64'(link_up_o), 64'd1);
      checkOutput("bad7_data_pushed", 64'(fifo_level_o), 64'd3);
      checkOutput("bad7_err_cnt", 64'(err_cnt_o), 64'd15);
      applyStimulus(HDR_BAD, 64'h0);
      checkOutput("bad_run_restarted", 64'(link_up_o), 64'd1);
      checkOutput("bad_err_cnt16", 64'(err_cnt_o), 64'd16);

      // Lock loss with 5 words queued
      applyStimulus(HDR_DATA, 64'hA4);
      applyStimulus(HDR_DATA, 64'hA5);
      checkOutput("lock_pre_level", 64'(fifo_level_o), 64'd5);
      lane_locked_i = 1'b0;
      idleCycles(1);
      lane_locked_i = 1'b1;
      checkOutput("lock_flush_level", 64'(fifo_level_o), 64'd0);
      checkOutput("lock_flush_valid", 64'(data_valid_o), 64'd0);
      checkOutput("lock_link_down", 64'(link_up_o), 64'd0);
      checkOutput("lock_err_kept", 64'(err_cnt_o), 64'd16);
      checkOutput("lock_drop_kept", 64'(drop_cnt_o), 64'd4);
      checkOutput("lock_ovf_kept", 64'(ovf_o), 64'd1);
      idleCycles(1);
      for (int i = 0; i < 4; i++) applyStimulus(HDR_CTRL, BLK_IDLE);
      checkOutput("relock_up", 64'(link_up_o), 64'd1);

      // Pop on an empty FIFO is ignored
      data_ready_i = 1'b1;
      idleCycles(1);
      data_ready_i = 1'b0;
      checkOutput("empty_pop_level", 64'(fifo_level_o), 64'd0);

      // Error counter saturation and clear priority
      force dut.err_cnt_q = 16'hFFFE;
      idleCycles(1);
      release dut.err_cnt_q;
      idleCycles(1);
      checkOutput("sat_preload", 64'(err_cnt_o), 64'hFFFE);
      applyStimulus(HDR_CTRL, BLK_UNKNOWN);
      checkOutput("sat_reach_max", 64'(err_cnt_o), 64'hFFFF);
      applyStimulus(HDR_CTRL, BLK_UNKNOWN);
      applyStimulus(HDR_CTRL, BLK_UNKNOWN);
      checkOutput("sat_hold_max", 64'(err_cnt_o), 64'hFFFF);
      applyStimulus(HDR_CTRL, BLK_NFC);
      checkOutput("nfc_no_err", 64'(err_cnt_o), 64'hFFFF);
      checkOutput("nfc_not_pushed", 64'(fifo_level_o), 64'd0);
      cnt_clr_i = 1'b1;
      applyStimulus(HDR_CTRL, BLK_UNKNOWN);
      cnt_clr_i = 1'b0;
      checkOutput("clr_err_cnt", 64'(err_cnt_o), 64'd0);
      checkOutput("clr_ovf", 64'(ovf_o), 64'd0);
      checkOutput("clr_drop_cnt", 64'(drop_cnt_o), 64'd0);
      applyStimulus(HDR_CTRL, BLK_UNKNOWN);
      checkOutput("post_clr_count", 64'(err_cnt_o), 64'd1);

      // Asynchronous reset in the middle of traffic
      applyStimulus(HDR_DATA, 64'hB1);
      checkOutput("mid_pre_level", 64'(fifo_level_o), 64'd1);
      #2 rst_n_i = 1'b0;
      #1;
      checkOutput("mid_rst_level", 64'(fifo_level_o), 64'd0);
      checkOutput("mid_rst_link", 64'(link_up_o), 64'd0);
      checkOutput("mid_rst_err", 64'(err_cnt_o), 64'd0);
      checkOutput("mid_rst_reg_data", reg_data_o, 64'd0);
      @(negedge clk_rx_i);
      rst_n_i = 1'b1;
      idleCycles(2);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
